// File: rtl/ram_readout_ctrl_if.sv
// rtl/ram_readout_ctrl_if.sv - readback port bundle between the DRAM/core top level and ram_readout_ctrl
interface ram_readout_ctrl_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int NCORES = 8
);
   logic [NCORES-1:0] busy;
   logic              start_scan;
   logic              manual_rd;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] ram_q;
   logic              own;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W-1:0] rd_addr;
   logic              valid;
   logic              done;
   logic [DATA_W-1:0] checksum;

   modport slave (
      input  busy, start_scan, manual_rd, sel_addr, ram_q,
      output own, ram_addr, rd_data, rd_addr, valid, done, checksum
   );

   modport master (
      output busy, start_scan, manual_rd, sel_addr, ram_q,
      input  own, ram_addr, rd_data, rd_addr, valid, done, checksum
   );
endinterface

// File: rtl/ram_readout_ctrl.sv
// rtl/ram_readout_ctrl.sv - post-run DRAM readback (manual/auto-scan); optional scan checksum under READOUT_CHECKSUM_EN
module ram_readout_ctrl #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int NCORES   = 8,
   parameter int QUAL_CYC = 4,
   parameter int HOLD_CYC = 16
) (
   input logic clk,
   input logic rst,
   ram_readout_ctrl_if.slave bus
);
   localparam int QW = (QUAL_CYC > 1) ? $clog2(QUAL_CYC + 1) : 1;
   localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC + 1) : 1;
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
   localparam logic [QW-1:0] QUAL_LAST = QW'(QUAL_CYC - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

   typedef enum logic [2:0] {
      S_WAIT_IDLE,
      S_OWNED,
      S_RD_ADDR,
      S_RD_CAP,
      S_SCAN_ADDR,
      S_SCAN_CAP,
      S_SCAN_HOLD
   } state_t;

   state_t            state, state_n;
   logic [QW-1:0]     qual_cnt, qual_cnt_n;
   logic [HW-1:0]     hold_cnt, hold_cnt_n;
   logic [ADDR_W-1:0] ram_addr_r, ram_addr_n;
   logic [DATA_W-1:0] rd_data_r, rd_data_n;
   logic [ADDR_W-1:0] rd_addr_r, rd_addr_n;
   logic              valid_r, valid_n;
   logic              done_r, done_n;
   logic              armed, armed_n;
   logic              own_r;
   logic              man_d;
   logic              busy_any;
   logic              man_rise;

   assign busy_any = |bus.busy;
   assign man_rise = bus.manual_rd & ~man_d;

   // State and datapath registers; own follows the owned states one cycle late and drops with busy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_WAIT_IDLE;
         qual_cnt   <= '0;
         hold_cnt   <= '0;
         ram_addr_r <= '0;
         rd_data_r  <= '0;
         rd_addr_r  <= '0;
         valid_r    <= 1'b0;
         done_r     <= 1'b0;
         armed      <= 1'b1;
         own_r      <= 1'b0;
         man_d      <= 1'b0;
      end else begin
         state      <= state_n;
         qual_cnt   <= qual_cnt_n;
         hold_cnt   <= hold_cnt_n;
         ram_addr_r <= ram_addr_n;
         rd_data_r  <= rd_data_n;
         rd_addr_r  <= rd_addr_n;
         valid_r    <= valid_n;
         done_r     <= done_n;
         armed      <= armed_n;
         own_r      <= (state != S_WAIT_IDLE) && !busy_any;
         man_d      <= bus.manual_rd;
      end
   end

   // Next-state and datapath updates; busy in any owned state abandons the read and releases the port
   always_comb begin
      state_n    = state;
      qual_cnt_n = qual_cnt;
      hold_cnt_n = hold_cnt;
      ram_addr_n = ram_addr_r;
      rd_data_n  = rd_data_r;
      rd_addr_n  = rd_addr_r;
      valid_n    = 1'b0;
      done_n     = done_r;
      armed_n    = armed | ~bus.start_scan;
      if (state != S_WAIT_IDLE && busy_any) begin
         state_n    = S_WAIT_IDLE;
         qual_cnt_n = '0;
         hold_cnt_n = '0;
         done_n     = 1'b0;
      end else begin
         case (state)
            S_WAIT_IDLE: begin
               if (busy_any) begin
                  qual_cnt_n = '0;
               end else if (qual_cnt == QUAL_LAST) begin
                  qual_cnt_n = '0;
                  state_n    = S_OWNED;
               end else begin
                  qual_cnt_n = qual_cnt + 1'b1;
               end
            end
            S_OWNED: begin
               // Commands wait until own is actually visible to the top-level mux
               if (own_r) begin
                  if (bus.start_scan && armed) begin
                     state_n    = S_SCAN_ADDR;
                     ram_addr_n = '0;
                     done_n     = 1'b0;
                     armed_n    = 1'b0;
                  end else if (man_rise) begin
                     state_n    = S_RD_ADDR;
                     ram_addr_n = bus.sel_addr;
                  end
               end
            end
            S_RD_ADDR: state_n = S_RD_CAP;
            S_RD_CAP: begin
               rd_data_n = bus.ram_q;
               rd_addr_n = ram_addr_r;
               valid_n   = 1'b1;
               state_n   = S_OWNED;
            end
            S_SCAN_ADDR: state_n = S_SCAN_CAP;
            S_SCAN_CAP: begin
               rd_data_n  = bus.ram_q;
               rd_addr_n  = ram_addr_r;
               valid_n    = 1'b1;
               hold_cnt_n = '0;
               state_n    = S_SCAN_HOLD;
            end
            S_SCAN_HOLD: begin
               if (hold_cnt == HOLD_LAST) begin
                  hold_cnt_n = '0;
                  if (ram_addr_r == ADDR_MAX) begin
                     done_n  = 1'b1;
                     state_n = S_OWNED;
                  end else begin
                     ram_addr_n = ram_addr_r + 1'b1;
                     state_n    = S_SCAN_ADDR;
                  end
               end else begin
                  hold_cnt_n = hold_cnt + 1'b1;
               end
            end
            default: state_n = S_WAIT_IDLE;
         endcase
      end
   end

`ifdef READOUT_CHECKSUM_EN
   logic [DATA_W-1:0] sum_r;

   // Running sum of scan captures, restarted whenever a new scan begins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_r <= '0;
      end else if (state == S_OWNED && state_n == S_SCAN_ADDR) begin
         sum_r <= '0;
      end else if (state == S_SCAN_CAP && state_n == S_SCAN_HOLD) begin
         sum_r <= sum_r + bus.ram_q;
      end
   end

   assign bus.checksum = sum_r;
`else
   assign bus.checksum = '0;
`endif

   assign bus.own      = own_r;
   assign bus.ram_addr = ram_addr_r;
   assign bus.rd_data  = rd_data_r;
   assign bus.rd_addr  = rd_addr_r;
   assign bus.valid    = valid_r;
   assign bus.done     = done_r;
endmodule

// File: tb/tb_ram_readout_ctrl.sv
// tb/tb_ram_readout_ctrl.sv - self-checking bench for ram_readout_ctrl
module tb_ram_readout_ctrl;
   localparam int ADDR_W   = 8;
   localparam int DATA_W   = 8;
   localparam int NCORES   = 8;
   localparam int QUAL_CYC = 4;
   localparam int HOLD_CYC = 16;

   logic clk;
   logic rst;

   ram_readout_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NCORES(NCORES)) bus ();

   ram_readout_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NCORES(NCORES),
      .QUAL_CYC(QUAL_CYC), .HOLD_CYC(HOLD_CYC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic [DATA_W-1:0] mem [256];

   int total = 0;
   int bad = 0;
   int mode = 0;
   int scan_id = 0;
   logic [ADDR_W-1:0] exp_manual_addr = '0;

   int cyc = 0;
   int cur_scan_id = 0;
   int next_addr = 0;
   int n_scan = 0;
   int n_manual = 0;
   int last_valid_cyc = -1;
   logic [DATA_W-1:0] model_sum = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM: address registered on one edge, data visible after it
   always @(posedge clk) bus.ram_q <= mem[bus.ram_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_own(input string name);
      int n;
      n = 0;
      while (bus.own !== 1'b1 && n < 30) begin
         step();
         n++;
      end
      check(name, n, QUAL_CYC + 1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_own"}, bus.own, 0);
      check({tag, "_ram_addr"}, bus.ram_addr, 0);
      check({tag, "_rd_data"}, bus.rd_data, 0);
      check({tag, "_rd_addr"}, bus.rd_addr, 0);
      check({tag, "_valid"}, bus.valid, 0);
      check({tag, "_done"}, bus.done, 0);
      check({tag, "_checksum"}, bus.checksum, 0);
   endtask

   // Per-cycle comparison of every capture against the expected read sequence
   task automatic monitor();
      cyc++;
`ifndef READOUT_CHECKSUM_EN
      check("checksum_tied_zero", bus.checksum, 0);
`endif
      if (bus.valid === 1'b1) begin
         check("valid_while_owned", bus.own, 1);
         if (mode == 1) begin
            check("manual_rd_addr", bus.rd_addr, exp_manual_addr);
            check("manual_rd_data", bus.rd_data, mem[exp_manual_addr]);
            n_manual++;
         end else if (mode == 2) begin
            if (scan_id != cur_scan_id) begin
               cur_scan_id = scan_id;
               next_addr = 0;
               n_scan = 0;
               model_sum = '0;
            end else begin
               check("scan_spacing", cyc - last_valid_cyc, HOLD_CYC + 2);
            end
            check("scan_rd_addr", bus.rd_addr, next_addr);
            check("scan_rd_data", bus.rd_data, mem[next_addr]);
            model_sum = model_sum + mem[next_addr];
`ifdef READOUT_CHECKSUM_EN
            check("scan_checksum_running", bus.checksum, model_sum);
`endif
            next_addr++;
            n_scan++;
            last_valid_cyc = cyc;
         end else begin
            check("unexpected_valid", bus.valid, 0);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      rst = 1'b1;
      bus.busy = 8'h01;
      bus.start_scan = 1'b0;
      bus.manual_rd = 1'b0;
      bus.sel_addr = '0;
      fork
         forever begin
            @(negedge clk);
            if (!rst) monitor();
         end
      join_none

      // Reset state
      repeat (3) step();
      check_all_zero("reset");
      rst = 1'b0;

      // Qualification: held busy, then a glitch that restarts the idle count
      repeat (20) step();
      check("own_while_busy", bus.own, 0);
      bus.busy = '0;
      step();
      step();
      bus.busy = 8'h20;
      step();
      check("own_after_glitch", bus.own, 0);
      bus.busy = '0;
      wait_own("qual_latency");

      // Manual read
      mode = 1;
      mem[8'h3C] = 8'hA5;
      exp_manual_addr = 8'h3C;
      bus.sel_addr = 8'h3C;
      bus.manual_rd = 1'b1;
      step();
      check("manual_ram_addr", bus.ram_addr, 8'h3C);
      check("manual_no_early_valid", bus.valid, 0);
      step();
      check("manual_no_valid_c1", bus.valid, 0);
      step();
      check("manual_valid", bus.valid, 1);
      check("manual_data_lit", bus.rd_data, 8'hA5);
      check("manual_addr_lit", bus.rd_addr, 8'h3C);
      repeat (5) step();
      bus.manual_rd = 1'b0;
      step();
      check("manual_single_pulse", n_manual, 1);
      mem[8'h3C] = 8'h3C;

      // Full auto-scan with start_scan held high
      mode = 2;
      scan_id++;
      bus.start_scan = 1'b1;
      begin
         int n;
         n = 0;
         while (bus.done !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
         end
      end
      check("scan_done", bus.done, 1);
      check("scan_count", n_scan, 256);
      check("scan_last_addr", bus.rd_addr, 8'hFF);
      check("scan_last_data", bus.rd_data, 8'hFF);
      check("scan_no_wrap", bus.ram_addr, 8'hFF);
`ifdef READOUT_CHECKSUM_EN
      check("model_sum_lit", model_sum, 8'h80);
      check("checksum_at_done", bus.checksum, 8'h80);
`else
      check("checksum_at_done", bus.checksum, 8'h00);
`endif
      repeat (60) step();
      check("no_restart_count", n_scan, 256);
      check("no_restart_done", bus.done, 1);
      check("no_restart_addr", bus.ram_addr, 8'hFF);

      // Scan aborted by busy while ram_addr=0x40
      bus.start_scan = 1'b0;
      step();
      scan_id++;
      bus.start_scan = 1'b1;
      step();
      bus.start_scan = 1'b0;
      check("restart_clears_done", bus.done, 0);
      begin
         int n;
         n = 0;
         while (bus.ram_addr !== 8'h40 && n < 2000) begin
            @(negedge clk);
            n++;
         end
      end
      check("reached_0x40", bus.ram_addr, 8'h40);
      bus.busy = 8'h20;
      step();
      check("abort_own", bus.own, 0);
      check("abort_done", bus.done, 0);
      repeat (5) step();
      check("abort_count", n_scan, 64);
      check("abort_rd_addr", bus.rd_addr, 8'h3F);
      check("abort_rd_data", bus.rd_data, 8'h3F);
      bus.busy = '0;
      wait_own("requal_after_abort");
      scan_id++;
      bus.start_scan = 1'b1;
      step();
      bus.start_scan = 1'b0;
      begin
         int n;
         n = 0;
         while (bus.valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
         end
      end
      check("restart_first_valid", bus.valid, 1);
      check("restart_from_zero", bus.rd_addr, 8'h00);

      // Asynchronous reset in the middle of a scan
      begin
         int n;
         n = 0;
         while (bus.ram_addr !== 8'h03 && n < 200) begin
            @(negedge clk);
            n++;
         end
      end
      @(posedge clk);
      #3;
      rst = 1'b1;
      mode = 0;
      #1;
      check_all_zero("async_rst");
      step();
      rst = 1'b0;
      check("own_after_rst", bus.own, 0);
      wait_own("requal_after_rst");
      repeat (5) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ram_readout_ctrl.md
Name: ram_readout_ctrl

Overview:
- Post-run readback stage downstream of the DRAM port in the 8-core top level.
- Waits until every core has deasserted busy, then takes ownership of the DRAM address port via the `own` mux select.
- Reads words either manually (switch-selected address) or by auto-scanning the whole address space.
- Presents each word and its address to the LEDR/HEX display logic.

Parameters:
ADDR_W, 8, DRAM address width
DATA_W, 8, DRAM word width
NCORES, 8, number of core busy inputs
QUAL_CYC, 4, consecutive all-idle cycles required before ownership is taken (min 1)
HOLD_CYC, 16, cycles each scanned word is held on rd_data before the next address (min 1)

Ports:
clk  in  1  system clock (divided CLK domain, same as DRAM/cores)
rst  in  1  asynchronous active-high reset
busy  in  NCORES  per-core busy flags
start_scan  in  1  level; start an auto-scan from address 0 while owned
manual_rd  in  1  level; read sel_addr once per rising edge detected
sel_addr  in  ADDR_W  manual read address
ram_q  in  DATA_W  DRAM q (registered-address synchronous RAM)
own  out  1  high = top level muxes ram_addr onto DRAM address and forces wren=0
ram_addr  out  ADDR_W  DRAM address while owned
rd_data  out  DATA_W  last captured word
rd_addr  out  ADDR_W  address of rd_data
valid  out  1  one-cycle pulse when rd_data/rd_addr update
done  out  1  level; auto-scan completed full address range
checksum  out  DATA_W  see Optional Feature

Behaviour:
- Reset (async): state=WAIT_IDLE.
  - own=0, ram_addr=0, rd_data=0, rd_addr=0, valid=0, done=0, checksum=0.
  - Qualification counter=0, edge detector for manual_rd cleared to 0.
- WAIT_IDLE:
  - Counter increments each cycle busy==0 and clears on any busy bit high.
  - When counter reaches QUAL_CYC-1 with busy==0 -> OWNED; own=1 from the next cycle.
- OWNED (idle while owned):
  - start_scan=1 -> SCAN_ADDR, ram_addr=0, done=0, checksum=0.
  - Else a manual_rd rising edge -> RD_ADDR, ram_addr=sel_addr.
  - start_scan has priority over manual_rd when both occur in the same cycle.
- Read latency:
  - ram_addr is registered; the RAM registers it on the next edge, and q is captured on the edge after that.
  - rd_data/rd_addr/valid therefore update exactly 2 cycles after ram_addr changes.
  - States RD_ADDR -> RD_CAP (manual) and SCAN_ADDR -> SCAN_CAP (scan) each span one cycle, then capture.
- Manual: after capture -> OWNED.
- Scan:
  - After SCAN_CAP -> SCAN_HOLD for HOLD_CYC cycles.
  - If ram_addr == 2^ADDR_W-1: done=1, go to OWNED (no wrap; address stays at max).
  - Else ram_addr+1 -> SCAN_ADDR.
  - Address arithmetic is ADDR_W-bit unsigned.
- start_scan still high at done: no restart until it is seen low for at least one cycle (scan re-arm).
- Busy reasserted in any owned state (OWNED, RD_*, SCAN_*):
  - Next cycle own=0, state=WAIT_IDLE, counter=0.
  - Any in-flight read is discarded (no valid); rd_data/rd_addr hold; done cleared.
- valid is never asserted while own=0.
- done clears on a new scan start or on loss of ownership.
- Core traffic and this block never drive DRAM in the same cycle; own is the only mux select.

Optional Feature:
- Macro READOUT_CHECKSUM_EN.
- Defined:
  - checksum accumulates the mod-2^DATA_W sum of every word captured during an auto-scan, updated on each scan valid.
  - Cleared at scan start and on reset.
  - Final value is stable while done=1.
  - Manual reads do not affect it.
- Undefined: checksum tied to 0, no accumulator logic.

Test Plan:
1. busy=8'h01 for 20 cycles, then 0 -> own rises exactly QUAL_CYC+1=5 cycles after busy falls; a busy glitch at cycle 2 restarts the count.
2. Owned, RAM[0x3C]=0xA5, sel_addr=0x3C, manual_rd pulse -> ram_addr=0x3C next cycle; rd_data=0xA5, rd_addr=0x3C with a single valid pulse 2 cycles later.
3. Owned, RAM[i]=i, start_scan=1 -> 256 valid pulses spaced HOLD_CYC+2=18 cycles apart, rd_addr 0x00..0xFF in order; done=1 after the 0xFF capture; no wrap to 0; start_scan held high causes no restart.
4. Scan in progress at address 0x40, busy[5]=1 -> own=0 next cycle, no further valid, done=0, rd_addr stays 0x3F; after busy clears, start_scan restarts from 0x00.
5. With READOUT_CHECKSUM_EN, RAM[i]=i -> checksum=0x80 (sum 0..255 mod 256) at done; without the macro, checksum=0 throughout.
6. Assert rst mid-scan (asynchronous, between edges) -> all outputs 0 immediately; the block re-qualifies idle before taking ownership again.
